// File: rtl/ppu_pkg.sv
// Shared PPU pipeline types and constants.
package ppu_pkg;

  localparam int          SPRITE_FIFO_DEPTH  = 8;
  localparam logic [1:0]  TRANSPARENT_COLOUR = 2'h0;

  // One sprite pixel as held in the FIFO; prio is the BG-over-OBJ flag.
  typedef struct packed {
    logic [1:0] colour;
    logic       palette;
    logic       prio;
  } sprite_pixel_t;

endpackage

// File: rtl/sprite_pixel_fifo_merge.sv
// Per-slot merge of an incoming sprite pixel into an occupied FIFO slot.
// Only instantiated when SPRITE_FIFO_MERGE_EN is defined.
module SpritePixelMerge
  import ppu_pkg::*;
(
  input  sprite_pixel_t stored,
  input  sprite_pixel_t incoming,
  input  logic          below_count,
  output sprite_pixel_t merged
);

  // Occupied slots keep the earlier sprite unless it is transparent and the
  // new pixel is opaque; free slots take the new pixel outright.
  always_comb begin
    merged = incoming;
    if (below_count) begin
      if ((stored.colour == TRANSPARENT_COLOUR) && (incoming.colour != TRANSPARENT_COLOUR))
        merged = incoming;
      else
        merged = stored;
    end
  end

endmodule

// File: rtl/sprite_pixel_fifo.sv
// 8-slot sprite pixel FIFO feeding the BG/sprite mixer.
// Optional feature macro: SPRITE_FIFO_MERGE_EN (merge a row into a
// partially full FIFO). Without it such pushes are rejected and flagged.
module sprite_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = SPRITE_FIFO_DEPTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  tclk_in,
  input  logic                  flush_in,
  input  logic                  valid_pixels_in,
  input  logic [DEPTH-1:0][1:0] pixels_in,
  input  logic                  dmg_pallete_in,
  input  logic                  sprite_priority_in,
  input  logic                  pop_in,
  output logic                  sprite_fifo_empty_out,
  output logic                  pixel_valid_out,
  output logic [1:0]            pixel_out,
  output logic                  pallete_out,
  output logic                  priority_out,
  output logic [3:0]            count_out,
  output logic                  dropped_push_out
);

  sprite_pixel_t slots    [DEPTH];
  sprite_pixel_t shifted  [DEPTH];
  sprite_pixel_t incoming [DEPTH];
  sprite_pixel_t push_row [DEPTH];
  logic [3:0]    count;
  logic [3:0]    post_count;
  logic          popped;
  logic          accept;
  logic          dropped;

  // Pop is applied first so a same-cycle push sees the shifted contents.
  always_comb begin
    popped     = pop_in && (count != 4'd0);
    post_count = count - {3'b000, popped};
    for (int i = 0; i < DEPTH - 1; i++)
      shifted[i] = popped ? slots[i+1] : slots[i];
    shifted[DEPTH-1] = popped ? sprite_pixel_t'('0) : slots[DEPTH-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign incoming[i] = {pixels_in[i], dmg_pallete_in, sprite_priority_in};
`ifdef SPRITE_FIFO_MERGE_EN
    SpritePixelMerge u_merge (
      .stored      (shifted[i]),
      .incoming    (incoming[i]),
      .below_count (4'(i) < post_count),
      .merged      (push_row[i])
    );
`else
    assign push_row[i] = incoming[i];
`endif
  end

  // Decide whether this push lands; an empty FIFO always takes the row.
  always_comb begin
`ifdef SPRITE_FIFO_MERGE_EN
    accept = valid_pixels_in;
`else
    accept = valid_pixels_in && (post_count == 4'd0);
`endif
  end

  // State update on T-cycle enables: flush beats pop beats push.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count   <= 4'd0;
      dropped <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (tclk_in) begin
      if (flush_in) begin
        count   <= 4'd0;
        dropped <= 1'b0;
        for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else begin
        count   <= accept ? 4'(DEPTH) : post_count;
        dropped <= valid_pixels_in && !accept;
        for (int i = 0; i < DEPTH; i++) slots[i] <= accept ? push_row[i] : shifted[i];
      end
    end
  end

  assign sprite_fifo_empty_out = (count == 4'd0);
  assign pixel_valid_out       = (count != 4'd0);
  assign pixel_out             = pixel_valid_out ? slots[0].colour  : 2'd0;
  assign pallete_out           = pixel_valid_out ? slots[0].palette : 1'b0;
  assign priority_out          = pixel_valid_out ? slots[0].prio    : 1'b0;
  assign count_out             = count;
  assign dropped_push_out      = dropped;

endmodule
